// File: rtl/text_pkg.sv
// Shared constants, FSM state type and ROM address helper for the text line renderer.
package text_pkg;

  localparam int unsigned GLYPH_W    = 8;
  localparam int unsigned GLYPH_H    = 16;
  localparam logic [7:0]  CHAR_SPACE = 8'h20;

  typedef enum logic [1:0] {StIdle, StFetch, StShift} state_e;

  // Codes with bit 7 set are rendered blank, but the ROM address stays within 0..127.
  function automatic logic [7:0] rom_addr(input logic [7:0] code);
    return {1'b0, code[6:0]};
  endfunction

endpackage

// File: rtl/text_line_buf.sv
// One-line text buffer: COLS character codes, one write port, one asynchronous read port.
module text_line_buf
  import text_pkg::*;
#(
  parameter int unsigned COLS  = 16,
  parameter int unsigned ADDRW = $clog2(COLS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [ADDRW-1:0] wr_addr_i,
  input  logic [7:0]       wr_data_i,
  input  logic [ADDRW-1:0] rd_addr_i,
  output logic [7:0]       rd_data_o
);

  // Sized to the full address space so out-of-range columns need no guard logic.
  localparam int unsigned Depth = 2 ** ADDRW;

  logic [7:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= CHAR_SPACE;
      end
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/char_line_renderer.sv
// Walks the text buffer through an external char_rom and serializes each glyph row slice
// into a gap-free MSB-first pixel stream.
module char_line_renderer
  import text_pkg::*;
#(
  parameter int unsigned COLS  = 16,
  parameter int unsigned PIX_W = $clog2(COLS * 8)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [3:0]              row_i,
  input  logic                    wr_en_i,
  input  logic [$clog2(COLS)-1:0] wr_addr_i,
  input  logic [7:0]              wr_data_i,
  output logic [7:0]              rom_char_o,
  output logic [3:0]              rom_row_o,
  input  logic [7:0]              rom_data_i,
  output logic                    pixel_o,
  output logic                    pixel_valid_o,
  output logic [PIX_W-1:0]        pix_x_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int unsigned     ColW    = $clog2(COLS);
  localparam logic [ColW-1:0] LastCol = ColW'(COLS - 1);

  state_e          state_q;
  logic [ColW-1:0] col_q;
  logic [2:0]      bit_q;
  logic [3:0]      row_q;
  logic [7:0]      shift_q;
  logic            done_q;

  logic [ColW-1:0] rd_addr;
  logic [7:0]      rd_code;
  logic [7:0]      slice;
  logic            prefetch;

  text_line_buf #(
    .COLS  (COLS),
    .ADDRW (ColW)
  ) u_buf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (wr_en_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_code)
  );

  always_comb begin
    prefetch   = (state_q == StShift) && (bit_q == 3'd7) && (col_q != LastCol);
    rd_addr    = prefetch ? col_q + ColW'(1) : col_q;
    rom_char_o = CHAR_SPACE;
    if ((state_q == StFetch) || prefetch) begin
      rom_char_o = rom_addr(rd_code);
    end
    slice = rd_code[7] ? 8'h00 : rom_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      col_q   <= '0;
      bit_q   <= '0;
      row_q   <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            row_q   <= row_i;
            col_q   <= '0;
            state_q <= StFetch;
          end
        end
        StFetch: begin
          shift_q <= slice;
          bit_q   <= '0;
          state_q <= StShift;
        end
        StShift: begin
          if (bit_q == 3'd7) begin
            bit_q <= '0;
            if (col_q != LastCol) begin
              // Load the next glyph on the last bit so the stream has no gap.
              shift_q <= slice;
              col_q   <= col_q + ColW'(1);
            end else begin
              col_q   <= '0;
              state_q <= StIdle;
              done_q  <= 1'b1;
            end
          end else begin
            shift_q <= {shift_q[6:0], 1'b0};
            bit_q   <= bit_q + 3'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    pixel_valid_o = (state_q == StShift);
    pixel_o       = pixel_valid_o & shift_q[7];
    pix_x_o       = '0;
    if (pixel_valid_o) begin
      pix_x_o = (PIX_W'(col_q) << 3) + PIX_W'(bit_q);
    end
    rom_row_o = row_q;
    busy_o    = (state_q != StIdle);
    done_o    = done_q;
  end

endmodule

// File: tb/tb_char_line_renderer.sv
// Directed bench for char_line_renderer with a small behavioural glyph ROM.
module tb_char_line_renderer;

  localparam int unsigned Cols = 4;
  localparam int unsigned PixW = $clog2(Cols * 8);

  logic            clk = 1'b0;
  logic            rst, start, wr_en;
  logic [3:0]      row;
  logic [1:0]      wr_addr;
  logic [7:0]      wr_data;
  logic [7:0]      rom_char;
  logic [3:0]      rom_row;
  logic [7:0]      rom_data;
  logic            pixel, pixel_valid, busy, done;
  logic [PixW-1:0] pix_x;

  int n_vec = 0;
  int n_err = 0;

  char_line_renderer #(
    .COLS (Cols)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .row_i         (row),
    .wr_en_i       (wr_en),
    .wr_addr_i     (wr_addr),
    .wr_data_i     (wr_data),
    .rom_char_o    (rom_char),
    .rom_row_o     (rom_row),
    .rom_data_i    (rom_data),
    .pixel_o       (pixel),
    .pixel_valid_o (pixel_valid),
    .pix_x_o       (pix_x),
    .busy_o        (busy),
    .done_o        (done)
  );

  always #5 clk = ~clk;

  // Stand-in char_rom: a few known slices, spaces blank, everything else A5^row.
  function automatic logic [7:0] glyph(input logic [7:0] c, input logic [3:0] r);
    if (c == 8'h20) return 8'h00;
    case ({c, r})
      12'h300: return 8'h3C;
      12'h310: return 8'h18;
      12'h311: return 8'h38;
      12'h320: return 8'h7E;
      12'h330: return 8'hC3;
      12'h411: return 8'h24;
      default: return 8'hA5 ^ {4'h0, r};
    endcase
  endfunction

  always_comb rom_data = glyph(rom_char, rom_row);

  typedef struct {
    logic [31:0] codes;
    logic [3:0]  row;
    logic [31:0] exp_pix;
    logic [31:0] exp_rc;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_buf(input logic [31:0] codes);
    for (int i = 0; i < 4; i++) begin
      tick();
      wr_en   = 1'b1;
      wr_addr = 2'(i);
      wr_data = codes[31-8*i -: 8];
    end
    tick();
    wr_en = 1'b0;
  endtask

  // Starts a line at cycle T and returns at the negedge of the done cycle.
  task automatic run_line(input logic [3:0] r, input int wr_at, input logic [1:0] wa,
                          input logic [7:0] wd, input int start_at,
                          output logic [31:0] pix, output logic [31:0] rc,
                          output int nvalid, output int done_at);
    int nbusy;
    pix = '0; rc = '0; nvalid = 0; done_at = -1; nbusy = 0;
    tick();
    start = 1'b1;
    row   = r;
    wr_en = 1'b0;
    for (int c = 1; c <= 40 && done_at < 0; c++) begin
      tick();
      start   = (c == start_at);
      wr_en   = (c == wr_at);
      wr_addr = wa;
      wr_data = wd;
      @(negedge clk);
      if (c == 1) begin
        check("fetch_busy", 32'(busy), 1);
        check("fetch_novalid", 32'(pixel_valid), 0);
        check("fetch_row", 32'(rom_row), 32'(r));
      end
      if (((c - 1) % 8 == 0) && c <= 25) rc[31-8*((c-1)/8) -: 8] = rom_char;
      if (busy) nbusy++;
      if (pixel_valid) begin
        check("pix_x", 32'(pix_x), 32'(nvalid));
        if (nvalid < 32) pix[31-nvalid] = pixel;
        nvalid++;
      end
      if (done) begin
        done_at = c;
        check("done_idle", 32'(busy | pixel_valid), 0);
      end
    end
    start = 1'b0;
    wr_en = 1'b0;
    check("busy_len", 32'(nbusy), 33);
  endtask

  initial begin
    logic [31:0] pix, rc;
    int nv, da, ndone;
    bit got;

    vecs[0] = '{codes: 32'h30313233, row: 4'd0, exp_pix: 32'h3C187EC3, exp_rc: 32'h30313233};
    vecs[1] = '{codes: 32'h31412020, row: 4'd1, exp_pix: 32'h38240000, exp_rc: 32'h31412020};
    vecs[2] = '{codes: 32'h30313280, row: 4'd0, exp_pix: 32'h3C187E00, exp_rc: 32'h30313200};
    vecs[3] = '{codes: 32'h55203130, row: 4'd2, exp_pix: 32'hA700A7A7, exp_rc: 32'h55203130};

    rst = 1'b1; start = 1'b0; wr_en = 1'b0; row = 4'd0; wr_addr = '0; wr_data = '0;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(pixel_valid), 0);
    check("rst_pixel", 32'(pixel), 0);
    check("rst_pix_x", 32'(pix_x), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rom_char", 32'(rom_char), 32'h20);
    check("rst_rom_row", 32'(rom_row), 0);

    for (int v = 0; v < 4; v++) begin
      write_buf(vecs[v].codes);
      run_line(vecs[v].row, -1, 2'd0, 8'h00, -1, pix, rc, nv, da);
      check($sformatf("v%0d_pix", v), pix, vecs[v].exp_pix);
      check($sformatf("v%0d_rom_char", v), rc, vecs[v].exp_rc);
      check($sformatf("v%0d_count", v), 32'(nv), 32);
      check($sformatf("v%0d_done_at", v), 32'(da), 34);
    end

    // start while busy is ignored; start coincident with done is accepted.
    write_buf(32'h30313233);
    run_line(4'd0, -1, 2'd0, 8'h00, 5, pix, rc, nv, da);
    check("busy_start_pix", pix, 32'h3C187EC3);
    check("busy_start_count", 32'(nv), 32);
    check("busy_start_done_at", 32'(da), 34);
    start = 1'b1;
    row   = 4'd0;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("b2b_fetch_busy", 32'(busy), 1);
    check("b2b_fetch_novalid", 32'(pixel_valid), 0);
    check("b2b_fetch_rom_char", 32'(rom_char), 32'h30);
    tick();
    @(negedge clk);
    check("b2b_first_valid", 32'(pixel_valid), 1);
    check("b2b_first_pix_x", 32'(pix_x), 0);
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      tick();
      @(negedge clk);
      if (done) got = 1'b1;
    end
    check("b2b_drain_done", 32'(got), 1);

    // Write col1 in the cycle it is prefetched: old code now, new code next line.
    run_line(4'd0, 9, 2'd1, 8'h41, -1, pix, rc, nv, da);
    check("wr_pf_pix_old", pix, 32'h3C187EC3);
    check("wr_pf_rc_old", rc, 32'h30313233);
    run_line(4'd0, -1, 2'd0, 8'h00, -1, pix, rc, nv, da);
    check("wr_pf_pix_new", pix, 32'h3CA57EC3);
    check("wr_pf_rc_new", rc, 32'h30413233);

    // Reset at pixel 20.
    tick();
    start = 1'b1;
    row   = 4'd3;
    for (int c = 1; c <= 22; c++) begin
      tick();
      start = 1'b0;
      if (c == 22) rst = 1'b1;
    end
    @(negedge clk);
    check("pre_rst_valid", 32'(pixel_valid), 1);
    check("pre_rst_pix_x", 32'(pix_x), 20);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(pixel_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_pix_x", 32'(pix_x), 0);
    check("mid_rst_rom_char", 32'(rom_char), 32'h20);
    check("mid_rst_rom_row", 32'(rom_row), 0);
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      @(negedge clk);
      if (done || pixel_valid) ndone++;
    end
    check("mid_rst_quiet", 32'(ndone), 0);
    run_line(4'd0, -1, 2'd0, 8'h00, -1, pix, rc, nv, da);
    check("rst_buf_pix", pix, 32'h00000000);
    check("rst_buf_rc", rc, 32'h20202020);
    check("rst_buf_count", 32'(nv), 32);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/char_line_renderer.md
# char_line_renderer

Sequencing controller for the `char_rom` glyph lookup. It holds a one-line text buffer of `COLS` character codes. On a `start` strobe it walks the buffer, drives `char_rom` with each code and the latched glyph row, and serializes every returned 8-bit row slice into a continuous MSB-first pixel stream. It sits between the display timing logic, which issues `start` and `row` per scanline, and the pixel output path.

## Interface
- `COLS`, default 16: characters per line, range 2..64.
- `PIX_W`, default $clog2(COLS*8): width of the pixel index.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin rendering one line. Sampled only in IDLE.
- `row` in 4: glyph row for this line. Latched on accepted `start`.
- `wr_en` in 1: text buffer write strobe.
- `wr_addr` in $clog2(COLS): buffer column to write.
- `wr_data` in 8: ASCII code to write.
- `rom_char` out 8: character address to `char_rom`.
- `rom_row` out 4: row address to `char_rom`.
- `rom_data` in 8: combinational glyph slice returned by `char_rom`.
- `pixel` out 1: current pixel. 1 means foreground.
- `pixel_valid` out 1: `pixel` and `pix_x` are meaningful this cycle.
- `pix_x` out PIX_W: index of the pixel within the line, 0..COLS*8-1.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse after the last pixel.

## Operation
- Buffer:
  - COLS×8 registers, reset to 0x20 on every entry.
  - Writes are accepted in any state.
  - A write to the column being fetched in the same cycle is not seen by that fetch, because the fetch reads the pre-write value.
- The FSM has three states: IDLE, FETCH and SHIFT.
- IDLE:
  - `start`=1 latches `row`, clears `col`=0 and moves to FETCH.
  - `start` in any other state is ignored.
- FETCH (one cycle):
  - `rom_char`=buf[col] and `rom_row`=row_q.
  - The shift register loads `rom_data` at the clock edge.
  - `bit`=0. Moves to SHIFT.
- SHIFT:
  - `pixel`=shift[7] and `pixel_valid`=1. The register shifts left each cycle and `bit` increments.
  - At `bit`=7 with `col`<COLS-1, the block prefetches: `rom_char`=buf[col+1], the shift register loads `rom_data`, `col` increments, `bit` wraps to 0 and the state stays SHIFT. There is no pixel gap between characters.
  - At `bit`=7 with `col`=COLS-1, the block moves to IDLE and `done` pulses in the following cycle.
- Code range: if buf[col][7]=1, the loaded slice is forced to 0x00 (blank pixels). `rom_char` still carries {1'b0, code[6:0]} so the ROM address stays within 0..127.
- `pix_x` = col*8+bit. It is held at 0 when `pixel_valid`=0.
- In IDLE, `rom_char`=0x20 and `rom_row`=row_q.

## Timing
- Reset values:
  - `pixel`=0, `pixel_valid`=0, `pix_x`=0, `busy`=0, `done`=0.
  - `rom_char`=0x20, `rom_row`=0.
  - FSM in IDLE, `col`=0, `bit`=0, buffer all 0x20.
- Latency with `start` accepted at cycle T:
  - FETCH runs in T+1.
  - The first pixel is valid in T+2.
  - The last pixel is valid in T+1+8·COLS.
  - `done` pulses in T+2+8·COLS.
  - `busy` is high for T+1..T+1+8·COLS.
- `start` asserted in the same cycle as `done` is accepted, because the FSM is already in IDLE. Back-to-back lines are therefore separated by exactly one FETCH cycle.
- `rst` mid-line:
  - The next cycle shows all reset values, with no `done` and no further pixels.
  - The buffer contents are lost.
- `char_rom` is combinational. The ROM path is `rom_char`/`rom_row` → `rom_data` → shift-register D, all within one cycle.

## Structure
- Shared package `text_pkg` holds:
  - `GLYPH_W`=8 and `GLYPH_H`=16.
  - `CHAR_SPACE`=8'h20.
  - The FSM state enum {IDLE, FETCH, SHIFT}.
- A single sub-module, `text_line_buf` (COLS×8 register file with one write port and one async read port), is natural. The FSM, counters and shifter stay in the top level.
- `char_rom` is instantiated by the parent, not inside this block.

## Test plan
- After reset, write "0123…" (0x30+i) to all columns, then `start` with `row`=0. Expect the first 8 pixels to be 00111100 at T+2..T+9, `pix_x` 0..7, and `done` at T+2+8·COLS.
- Write col0=0x31 and col1=0x41, `row`=1, COLS=2. Expect the stream 00111000 followed immediately by 00100100 with no gap, and `rom_char` sequence 0x31 then 0x41.
- Write code 0x80 to col3. Expect 8 zero pixels for `pix_x` 24..31 while `pixel_valid` stays 1, and `rom_char`=0x00 during that fetch.
- Pulse `start` at T+5 while busy. Expect it to be ignored with the pixel count unchanged. Then pulse `start` coincident with `done`. Expect FETCH next cycle and the first pixel two cycles after `done`.
- Write col1 in the exact cycle col1 is prefetched. Expect the old code rendered this line and the new code on the next line.
- Assert `rst` at mid-line pixel 20. Expect `pixel_valid`=0 and `busy`=0 on the next cycle, no `done`, and a buffer readback of 0x20 (spaces).
